// File: rtl/ascon_pack.sv
// Shared widths and packer state type for the ASCON input/output block queues.
package ascon_pack;

   localparam int BLOCK_WIDTH = 64;
   localparam int WORD_WIDTH  = 32;

   typedef enum logic {HalfEmpty, HalfFull} pack_state_e;

   // The first bus word of a pair is the high half of the rate block.
   function automatic logic [BLOCK_WIDTH-1:0] pack_block(input logic [WORD_WIDTH-1:0] high_word,
                                                         input logic [WORD_WIDTH-1:0] low_word);
      return {high_word, low_word};
   endfunction

endpackage

// File: rtl/ascon_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a separate occupancy counter.
module ascon_sync_fifo #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LVL_W-1:0] level_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;

   // Push and pop both qualify on registered state, so a full FIFO cannot take a block even while popping.
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset: data_o is forced to zero whenever nothing is queued.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= data_i;
      end
   end

   assign data_o = empty_o ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/ascon_in_buffer.sv
// Packs 32-bit bus words into 64-bit rate blocks and queues them for the ASCON core FSM.
module ascon_in_buffer
   import ascon_pack::*;
#(
   parameter int Depth         = 4,
   parameter int DataAddrWidth = 7
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush_i,
   input  logic [WORD_WIDTH-1:0]        wdata_i,
   input  logic                         wvalid_i,
   output logic                         wready_o,
   input  logic                         pop_i,
   output logic                         empty_o,
   output logic                         full_o,
   output logic [BLOCK_WIDTH-1:0]       data_o,
   output logic [$clog2(Depth+1)-1:0]   level_o,
   output logic                         half_o,
   output logic [DataAddrWidth-1:0]     blk_cnt_o,
   output logic                         err_o
);

   pack_state_e               state_q;
   pack_state_e               state_d;
   logic [WORD_WIDTH-1:0]     high_q;
   logic [DataAddrWidth-1:0]  blk_cnt_q;
   logic                      err_q;
   logic                      word_acc;
   logic                      latch_high;
   logic                      push_blk;
   logic                      fifo_full;
   logic                      fifo_empty;

   assign half_o    = (state_q == HalfFull);
   assign wready_o  = !half_o || !fifo_full;
   assign word_acc  = wvalid_i && wready_o && !flush_i;
   assign full_o    = fifo_full;
   assign empty_o   = fifo_empty;
   assign blk_cnt_o = blk_cnt_q;
   assign err_o     = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HalfEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   // A high word can always be latched; the low word only completes a block when the FIFO has room.
   always_comb begin
      state_d    = state_q;
      latch_high = 1'b0;
      push_blk   = 1'b0;
      if (word_acc) begin
         case (state_q)
            HalfEmpty: begin
               latch_high = 1'b1;
               state_d    = HalfFull;
            end
            HalfFull: begin
               push_blk = 1'b1;
               state_d  = HalfEmpty;
            end
         endcase
      end
      if (flush_i) begin
         state_d = HalfEmpty;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_q    <= '0;
         blk_cnt_q <= '0;
         err_q     <= 1'b0;
      end else if (flush_i) begin
         high_q    <= '0;
         blk_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (latch_high) begin
            high_q <= wdata_i;
         end
         if (push_blk) begin
            blk_cnt_q <= blk_cnt_q + DataAddrWidth'(1);
         end
         if (pop_i && fifo_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   ascon_sync_fifo #(
      .WIDTH (BLOCK_WIDTH),
      .DEPTH (Depth)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .push_i  (push_blk),
      .data_i  (pack_block(high_q, wdata_i)),
      .pop_i   (pop_i),
      .data_o  (data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level_o)
   );

endmodule
